// File: rtl/mp64_mem_arbiter.sv
// Purpose: shares one memory bus between the I-cache refill port and the CPU data port.
// Latency: one arbitration cycle (owner registered), then a combinational pass-through to memory.
// Backpressure: the granted master holds valid until its ready pulse; the other master sees ready=0, rdata=0.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ic_valid/ic_addr                 I-cache beat request (read only)
//   ic_rdata/ic_ready                I-cache beat data and one-cycle completion pulse
//   d_valid/d_addr/d_wen/d_size/d_wdata  data-port request
//   d_rdata/d_ready                  data-port read data and one-cycle completion pulse
//   mem_valid/addr/wen/size/wdata    request towards memory
//   mem_rdata/mem_ready              memory response (one ready pulse per beat)
//   owner                            current grant: 00 none, 01 ic, 10 d
//   stat_contention                  saturating count of cycles with both masters requesting
module mp64_mem_arbiter #(
    parameter int IC_BURST   = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ic_valid,
    input  logic [63:0] ic_addr,
    output logic [63:0] ic_rdata,
    output logic        ic_ready,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic        d_wen,
    input  logic [1:0]  d_size,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_ready,
    output logic        mem_valid,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [1:0]  mem_size,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  owner,
    output logic [31:0] stat_contention
);

    localparam logic [1:0] BUS_BYTE  = 2'd0;
    localparam logic [1:0] BUS_HALF  = 2'd1;
    localparam logic [1:0] BUS_WORD  = 2'd2;
    localparam logic [1:0] BUS_DWORD = 2'd3;

    localparam logic [3:0] LAST_BEAT  = 4'(IC_BURST - 1);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    // The encoding doubles as the owner output.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_IC = 2'b01,
        GNT_D  = 2'b10
    } state_t;

    state_t      state;
    logic [3:0]  beat_cnt;
    logic [7:0]  starve_cnt;
    logic [31:0] contention_cnt;

    logic d_wins;
    logic ic_wins;

    assign owner           = state;
    assign stat_contention = contention_cnt;

    // Data port has priority unless ic has already waited STARVE_MAX cycles.
    assign d_wins  = (state == IDLE) && d_valid && (starve_cnt < STARVE_LIM);
    assign ic_wins = (state == IDLE) && ic_valid && !d_wins;

    // Memory-side mux and response steering. Anything not owned reads as zero.
    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = 64'd0;
        mem_wen   = 1'b0;
        mem_size  = BUS_DWORD;
        mem_wdata = 64'd0;
        ic_ready  = 1'b0;
        ic_rdata  = 64'd0;
        d_ready   = 1'b0;
        d_rdata   = 64'd0;
        case (state)
            GNT_IC: begin
                mem_valid = ic_valid;
                mem_addr  = ic_addr;
                ic_ready  = mem_ready;
                ic_rdata  = mem_rdata;
            end
            GNT_D: begin
                mem_valid = d_valid;
                mem_addr  = d_addr;
                mem_wen   = d_wen;
                mem_size  = d_size;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
                d_rdata   = mem_rdata;
            end
            default: ;
        endcase
    end

    // Every transaction returns to IDLE, which guarantees at least one cycle
    // of mem_valid low between requests. mem_ready takes precedence over a
    // dropped valid, so a same-cycle drop still counts as completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state <= GNT_D;
                    end else if (ic_wins) begin
                        state <= GNT_IC;
                    end
                end
                GNT_IC: begin
                    // Burst lock: d_valid is not looked at until the line is done.
                    if (mem_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= IDLE;
                            beat_cnt <= 4'd0;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end else if (!ic_valid) begin
                        state    <= IDLE;
                        beat_cnt <= 4'd0;
                    end
                end
                GNT_D: begin
                    if (mem_ready || !d_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Counts consecutive cycles ic is requesting without owning the bus. It
    // clears when ic drops its request so a stale count cannot lock d out
    // while ic is absent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
        end else if (ic_wins || !ic_valid) begin
            starve_cnt <= 8'd0;
        end else if ((state != GNT_IC) && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contention_cnt <= 32'd0;
        end else if (ic_valid && d_valid && (contention_cnt != 32'hFFFF_FFFF)) begin
            contention_cnt <= contention_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mp64_mem_arbiter.sv
// Purpose: self-checking bench for mp64_mem_arbiter (directed scenarios plus randomized traffic).
// Latency: the model tracks the one-cycle arbitration and same-cycle pass-through.
// Backpressure: bench masters hold valid until their ready pulse; memory may stall or respond at once.
module tb_mp64_mem_arbiter;

    localparam int IC_BURST   = 2;
    localparam int STARVE_MAX = 8;
    localparam logic [63:0] RKEY = 64'h5A5A_0F0F_A5A5_F0F0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_valid = 1'b0;
    logic [63:0] ic_addr = 64'd0;
    logic [63:0] ic_rdata;
    logic        ic_ready;
    logic        d_valid = 1'b0;
    logic [63:0] d_addr = 64'd0;
    logic        d_wen = 1'b0;
    logic [1:0]  d_size = 2'd3;
    logic [63:0] d_wdata = 64'd0;
    logic [63:0] d_rdata;
    logic        d_ready;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  owner;
    logic [31:0] stat_contention;

    // Memory behaviour: 0 respond same cycle, 1 never, 2 ready stuck high, 3 random.
    int   mem_mode = 0;
    logic mem_ready_r = 1'b0;

    assign mem_rdata = mem_addr ^ RKEY;
    assign mem_ready = (mem_mode == 0) ? mem_valid :
                       (mem_mode == 2) ? 1'b1 :
                       (mem_mode == 3) ? mem_ready_r : 1'b0;

    always #5 clk = ~clk;

    mp64_mem_arbiter #(.IC_BURST(IC_BURST), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .d_valid(d_valid), .d_addr(d_addr), .d_wen(d_wen), .d_size(d_size),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner), .stat_contention(stat_contention)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who holds the bus, how many beats of the current
    // line are done, how long ic has been kept waiting, contention total.
    // ------------------------------------------------------------------
    int      m_own   = 0;   // 0 nobody, 1 ic, 2 d
    int      m_beats = 0;
    int      m_wait  = 0;
    longint  m_cont  = 0;

    always @(negedge clk) begin
        logic [63:0] e_addr, e_wdata, e_icr, e_dr;
        logic        e_mv, e_wen, e_icy, e_dy;
        logic [1:0]  e_size;
        int          nxt;
        if (!rst_n) begin
            m_own = 0; m_beats = 0; m_wait = 0; m_cont = 0;
        end
        e_mv = 1'b0; e_addr = 64'd0; e_wen = 1'b0; e_size = 2'd3; e_wdata = 64'd0;
        e_icy = 1'b0; e_icr = 64'd0; e_dy = 1'b0; e_dr = 64'd0;
        if (m_own == 1) begin
            e_mv = ic_valid; e_addr = ic_addr;
            e_icy = mem_ready; e_icr = mem_rdata;
        end else if (m_own == 2) begin
            e_mv = d_valid; e_addr = d_addr; e_wen = d_wen; e_size = d_size; e_wdata = d_wdata;
            e_dy = mem_ready; e_dr = mem_rdata;
        end
        chk("owner", 64'(owner), 64'(m_own));
        chk("mem_valid", 64'(mem_valid), 64'(e_mv));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wen", 64'(mem_wen), 64'(e_wen));
        chk("mem_size", 64'(mem_size), 64'(e_size));
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("ic_ready", 64'(ic_ready), 64'(e_icy));
        chk("ic_rdata", ic_rdata, e_icr);
        chk("d_ready", 64'(d_ready), 64'(e_dy));
        chk("d_rdata", d_rdata, e_dr);
        chk("stat_contention", 64'(stat_contention),
            (m_cont > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : 64'(m_cont));
        if (rst_n) begin
            nxt = m_own;
            if (m_own == 0) begin
                if (d_valid && m_wait < STARVE_MAX) nxt = 2;
                else if (ic_valid) nxt = 1;
            end else if (m_own == 1) begin
                if (mem_ready) begin
                    m_beats++;
                    if (m_beats == IC_BURST) begin nxt = 0; m_beats = 0; end
                end else if (!ic_valid) begin
                    nxt = 0; m_beats = 0;
                end
            end else begin
                if (mem_ready || !d_valid) nxt = 0;
            end
            if (!ic_valid || (m_own == 0 && nxt == 1)) m_wait = 0;
            else if (m_own != 1 && m_wait < STARVE_MAX) m_wait++;
            if (ic_valid && d_valid) m_cont++;
            m_own = nxt;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle log for the directed scenarios.
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic [1:0]  own_l [64];
    logic        mv_l  [64];
    logic [63:0] ma_l  [64];
    logic        icr_l [64];
    logic        dr_l  [64];
    logic        wen_l [64];
    logic [1:0]  sz_l  [64];
    logic        last_icr = 1'b0;
    logic        last_dr  = 1'b0;

    task automatic step();
        @(negedge clk);
        if (cyc < 64) begin
            own_l[cyc] = owner; mv_l[cyc] = mem_valid; ma_l[cyc] = mem_addr;
            icr_l[cyc] = ic_ready; dr_l[cyc] = d_ready; wen_l[cyc] = mem_wen; sz_l[cyc] = mem_size;
        end
        last_icr = ic_ready;
        last_dr  = d_ready;
        cyc++;
        @(posedge clk);
        #1;
        if (mem_mode == 3) mem_ready_r = ($urandom_range(0, 2) == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ic_valid = 1'b0; ic_addr = 64'd0;
        d_valid = 1'b0; d_addr = 64'd0; d_wen = 1'b0; d_size = 2'd3; d_wdata = 64'd0;
        mem_mode = 0;
        step();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    int first_ic, d_cnt, ic_left;

    initial begin
        // Reset state while rst_n is still low.
        #2;
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_size", 64'(mem_size), 64'd3);
        chk("rst_stat", 64'(stat_contention), 64'd0);

        // 1: lone ic refill, immediate memory.
        do_reset();
        ic_valid = 1'b1; ic_addr = 64'h100;
        step();
        step();
        ic_addr = 64'h108;
        step();
        ic_valid = 1'b0;
        step();
        step();
        chk("t1_owner_c0", 64'(own_l[0]), 64'd0);
        chk("t1_owner_c1", 64'(own_l[1]), 64'd1);
        chk("t1_beat0_addr", ma_l[1], 64'h100);
        chk("t1_beat0_ready", 64'(icr_l[1]), 64'd1);
        chk("t1_beat1_addr", ma_l[2], 64'h108);
        chk("t1_beat1_ready", 64'(icr_l[2]), 64'd1);
        chk("t1_idle_mv", 64'(mv_l[3]), 64'd0);
        chk("t1_idle_owner", 64'(own_l[3]), 64'd0);
        chk("t1_no_d_ready", 64'(dr_l[0] | dr_l[1] | dr_l[2] | dr_l[3] | dr_l[4]), 64'd0);

        // 2: simultaneous requests, d wins first.
        do_reset();
        ic_valid = 1'b1; ic_addr = 64'h400;
        d_valid = 1'b1; d_addr = 64'h200; d_wen = 1'b1; d_size = 2'd2; d_wdata = 64'hDEAD_BEEF;
        step();
        step();
        d_valid = 1'b0; d_wen = 1'b0;
        step();
        step();
        ic_addr = 64'h408;
        step();
        ic_valid = 1'b0;
        step();
        chk("t2_d_owner", 64'(own_l[1]), 64'd2);
        chk("t2_d_addr", ma_l[1], 64'h200);
        chk("t2_d_wen", 64'(wen_l[1]), 64'd1);
        chk("t2_d_size", 64'(sz_l[1]), 64'd2);
        chk("t2_d_ready", 64'(dr_l[1]), 64'd1);
        chk("t2_gap", 64'(mv_l[2]), 64'd0);
        chk("t2_ic_beats", 64'(icr_l[3] & icr_l[4]), 64'd1);
        chk("t2_ic_addr", ma_l[3], 64'h400);
        chk("t2_release", 64'(own_l[5]), 64'd0);
        chk("t2_contention", 64'(stat_contention), 64'd2);

        // 3: d arrives mid-burst; the line is not split.
        do_reset();
        ic_valid = 1'b1; ic_addr = 64'h500;
        step();
        step();
        ic_addr = 64'h508; d_valid = 1'b1; d_addr = 64'h600;
        step();
        ic_valid = 1'b0;
        step();
        step();
        d_valid = 1'b0;
        step();
        chk("t3_lock_owner", 64'(own_l[2]), 64'd1);
        chk("t3_lock_beat", 64'(icr_l[2]), 64'd1);
        chk("t3_gap_owner", 64'(own_l[3]), 64'd0);
        chk("t3_d_owner", 64'(own_l[4]), 64'd2);
        chk("t3_d_ready", 64'(dr_l[4]), 64'd1);

        // 4: back-to-back d traffic, ic must win once it has waited STARVE_MAX cycles.
        do_reset();
        ic_valid = 1'b1; ic_addr = 64'hC00;
        d_valid = 1'b1; d_addr = 64'h300;
        first_ic = -1; d_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (first_ic < 0 && own_l[i] == 2'd1) first_ic = i;
            if (first_ic < 0 && dr_l[i]) d_cnt++;
            if (first_ic >= 0 && i == first_ic + 1) ic_valid = 1'b0;
        end
        d_valid = 1'b0;
        step();
        chk("t4_first_ic_cycle", 64'(first_ic), 64'd9);
        chk("t4_d_grants_before", 64'(d_cnt), 64'd4);

        // 5: abort after one beat, then a fresh refill needs two beats.
        do_reset();
        ic_valid = 1'b1; ic_addr = 64'h900;
        step();
        step();
        mem_mode = 1; ic_addr = 64'h908;
        step();
        ic_valid = 1'b0;
        step();
        mem_mode = 0; ic_valid = 1'b1; ic_addr = 64'hA00;
        step();
        step();
        ic_addr = 64'hA08;
        step();
        ic_valid = 1'b0;
        step();
        chk("t5_abort_owner", 64'(own_l[3]), 64'd1);
        chk("t5_abort_idle", 64'(own_l[4]), 64'd0);
        chk("t5_beat0", 64'(icr_l[5]), 64'd1);
        chk("t5_still_locked", 64'(own_l[6]), 64'd1);
        chk("t5_beat1", 64'(icr_l[6]), 64'd1);
        chk("t5_release", 64'(own_l[7]), 64'd0);

        // 6: asynchronous reset between beats, then a stray mem_ready.
        do_reset();
        ic_valid = 1'b1; ic_addr = 64'h700;
        step();
        d_valid = 1'b1; d_addr = 64'h800;
        step();
        mem_mode = 1; ic_addr = 64'h708;
        step();
        chk("t6_pre_owner", 64'(owner), 64'd1);
        chk("t6_pre_stat", 64'(stat_contention), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_async_owner", 64'(owner), 64'd0);
        chk("t6_async_mv", 64'(mem_valid), 64'd0);
        chk("t6_async_stat", 64'(stat_contention), 64'd0);
        ic_valid = 1'b0; d_valid = 1'b0; mem_mode = 2;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_stray_in_reset", 64'(icr_l[3]), 64'd0);
        chk("t6_stray_after", 64'(icr_l[4]), 64'd0);
        chk("t6_owner_after", 64'(own_l[4]), 64'd0);
        mem_mode = 0;

        // Randomized traffic; the model compares every cycle.
        do_reset();
        mem_mode = 3;
        ic_left = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (i == 2000) begin
                rst_n = 1'b0; ic_valid = 1'b0; d_valid = 1'b0; ic_left = 0;
                step();
                rst_n = 1'b1;
            end else begin
                if (i % 500 == 0) mem_mode = ($urandom_range(0, 3) == 0) ? 0 : 3;
                if (ic_valid) begin
                    if (last_icr) begin
                        ic_left--; ic_addr = ic_addr + 64'd8;
                        if (ic_left == 0) ic_valid = 1'b0;
                    end else if ($urandom_range(0, 29) == 0) begin
                        ic_valid = 1'b0; ic_left = 0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    ic_valid = 1'b1; ic_left = IC_BURST;
                    ic_addr = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFF0;
                end
                if (d_valid) begin
                    if (last_dr || $urandom_range(0, 39) == 0) d_valid = 1'b0;
                end
                if (!d_valid && $urandom_range(0, 2) == 0) begin
                    d_valid = 1'b1; d_addr = {$urandom, $urandom};
                    d_wen = 1'($urandom); d_size = 2'($urandom); d_wdata = {$urandom, $urandom};
                end
            end
        end
        ic_valid = 1'b0; d_valid = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
